burst_ram: RTL and testbench
============================

Name: burst_ram

Overview:
- Parametrised single-port synchronous RAM with an internal address counter.
- The counter is the program counter generalised to ADDR_W bits.
- Supports single and burst transfers under a valid/ready command handshake.
- Successor to the fixed 2-bit status-gated RAM. The status input still locks out writes, but now reports an error instead of silently dropping.

Parameters:
- DATA_W, 8, width of each RAM word.
- DEPTH, 16, number of words; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), address and burst-length width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- status  in  1  write lock; 1 = writes forbidden, sampled at command accept.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  ADDR_W  burst beats minus 1 (0 = single word, DEPTH-1 = full array).
- wr_data  in  DATA_W  write beat data.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  block consumes write beat.
- rd_data  out  DATA_W  read beat data.
- rd_valid  out  1  rd_data valid this cycle.
- done  out  1  one-cycle pulse on completion of a burst.
- err  out  1  one-cycle pulse when a write command is rejected.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs after reset: cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, err=0.
  - FSM goes to IDLE; addr and beat counters clear to 0.
  - RAM contents are not reset.
- Accept: a command is accepted when cmd_valid && cmd_ready. Other command inputs are ignored.
- FSM IDLE (cmd_ready=1):
  - Read accepted -> RD. Load addr=cmd_addr, beats=cmd_len.
  - Write accepted with status=0 -> WR, with the same loads.
  - Write accepted with status=1 -> ERR.
- FSM WR (cmd_ready=0, wr_ready=1):
  - Each cycle with wr_valid=1 writes mem[addr]<=wr_data, then addr<=addr+1 and beats<=beats-1.
  - When wr_valid=0, nothing changes (stall).
  - A write on the final beat (beats==0) -> DONE.
  - status changes mid-burst are ignored.
- FSM RD (cmd_ready=0):
  - Every cycle reads mem[addr] and advances addr.
  - rd_data/rd_valid are registered: latency 1 cycle from entering RD, one beat per cycle, no backpressure.
  - After the final beat is issued -> DONE.
  - The last rd_valid coincides with the done pulse.
- FSM DONE: done=1 for one cycle, cmd_ready=0, then -> IDLE.
- FSM ERR: err=1 for one cycle, no RAM write, then -> IDLE.
- Address wrap: addr increments modulo DEPTH (DEPTH-1 -> 0).
  - Full-length bursts (cmd_len=DEPTH-1) touch every word exactly once.
- Command throughput: at most one command every len+3 cycles (accept, beats, DONE). No pipelining of commands.
- Reset mid-burst: aborts immediately; the next cycle is IDLE.
  - Any write already committed stays in RAM.
  - No done or err is produced for the aborted burst.
- Outside DONE/ERR, done and err are 0. rd_valid=0 outside the read output window.
- rd_data holds its last value when rd_valid=0.

Decomposition:
- Shared package burst_ram_pkg holds:
  - state enum {IDLE, WR, RD, DONE, ERR};
  - width helper function for ADDR_W.
- Natural sub-module: addr_counter, a parametrised ADDR_W-bit loadable wrap-around up-counter with enable and synchronous reset. It replaces the old toggle-chain program counter.
- The RAM array stays inline: a single-port, write-first-irrelevant array, since read and write never coincide.

Test Plan:
- Single write/read: write cmd addr=3 len=0 data=0xA5, status=0 -> done pulse 2 cycles after accept. Then read addr=3 len=0 -> rd_valid 1 cycle after RD entry with rd_data=0xA5, with done in that same cycle.
- Wrapping burst: write addr=14 len=3 data 0x11,0x22,0x33,0x44 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33, mem[1]=0x44. Read addr=14 len=3 -> same 4 values on consecutive rd_valid cycles.
- Write stall: write len=1 with a 3-cycle wr_valid=0 gap between beats -> wr_ready held 1; done only after the 2nd beat; exactly 2 words written.
- Status lock: status=1, write addr=5 len=0 data=0xFF -> err=1 one cycle, no done, mem[5] unchanged on read-back. Raising status mid write burst does not abort the burst.
- Reset mid-burst: reset=1 after 2 of 4 write beats -> next cycle cmd_ready=1, done=0, err=0. First 2 words are written; words 3-4 keep their old values.
- Full array: write len=DEPTH-1 with data=index, then read addr=0 len=15 -> rd_data 0..15 in order, followed by a single done pulse.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared types and helpers for the burst RAM: controller state encoding and
// the address-width derivation used by the top and its counter.
package burst_ram_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Address (and burst-length) width for a given power-of-two depth.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/burst_ram_addr_counter.sv
// Loadable wrap-around up-counter used as the RAM address pointer.
// Wrap at 2**ADDR_W falls out of the carry chain naturally.
module burst_ram_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] count
);

    logic [ADDR_W-1:0] count_reg;
    logic [ADDR_W-1:0] count_next;
    logic [ADDR_W-1:0] carry;

    // Ripple increment: each bit toggles when all lower bits are set.
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bit
            assign count_next[gi] = count_reg[gi] ^ carry[gi];
            if (gi < ADDR_W - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & count_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/burst_ram.sv
// Single-port synchronous RAM with an internal wrapping address counter,
// serving single/burst reads and writes behind a valid/ready command port.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int   DATA_W = 8,
    parameter int   DEPTH  = 16,
    localparam int  ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              status,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] beats_reg;
    logic [ADDR_W-1:0] beats_next;
    logic [ADDR_W-1:0] addr;
    logic              addr_load;
    logic              addr_en;
    logic              accept;
    logic              wr_beat;
    logic              rd_beat;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    assign accept  = cmd_valid && (state_reg == IDLE);
    assign wr_beat = (state_reg == WR) && wr_valid;
    assign rd_beat = (state_reg == RD);

    burst_ram_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .reset    (reset),
        .load     (addr_load),
        .en       (addr_en),
        .load_val (cmd_addr),
        .count    (addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            beats_reg <= '0;
        end else begin
            state_reg <= state_next;
            beats_reg <= beats_next;
        end
    end

    // beats_reg holds the number of beats still to go after the current one.
    always_comb begin
        state_next = state_reg;
        beats_next = beats_reg;
        addr_load  = 1'b0;
        addr_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (cmd_write && status) begin
                        state_next = ERR;
                    end else begin
                        addr_load  = 1'b1;
                        beats_next = cmd_len;
                        state_next = cmd_write ? WR : RD;
                    end
                end
            end
            WR: begin
                if (wr_valid) begin
                    addr_en    = 1'b1;
                    beats_next = beats_reg - ADDR_W'(1);
                    if (beats_reg == '0) begin
                        state_next = DONE;
                    end
                end
            end
            RD: begin
                addr_en    = 1'b1;
                beats_next = beats_reg - ADDR_W'(1);
                if (beats_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A reset arriving on a beat cycle must not commit that beat.
    always_ff @(posedge clk) begin
        if (wr_beat && !reset) begin
            mem[addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_beat;
            if (rd_beat) begin
                rd_data_reg <= mem[addr];
            end
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign wr_ready  = (state_reg == WR);
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == ERR);
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_burst_ram.sv
// Directed plus randomized bench for burst_ram against an array-based
// memory model; one line per transaction and a single result line.
module tb_burst_ram;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    logic          clk;
    logic          reset;
    logic          status;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int ref_mem [DEPTH];
    int wbuf [DEPTH];

    burst_ram #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .status    (status),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int len, input int gap_at,
                            input int gap_n, input bit raise_st);
        chk("wr_idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b1; status = 1'b0;
        cmd_addr = a[AW-1:0]; cmd_len = len[AW-1:0];
        tick();
        cmd_valid = 1'b0;
        chk("wr_state_wr_ready", wr_ready, 1);
        chk("wr_state_cmd_ready", cmd_ready, 0);
        for (int i = 0; i <= len; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_n; g++) begin
                    wr_valid = 1'b0;
                    tick();
                    chk("wr_stall_wr_ready", wr_ready, 1);
                    chk("wr_stall_done", done, 0);
                end
            end
            wr_valid = 1'b1;
            wr_data  = wbuf[i][DW-1:0];
            tick();
            ref_mem[(a + i) % DEPTH] = wbuf[i];
            if (raise_st && i == 0) status = 1'b1;
            chk("wr_beat_done", done, (i == len) ? 1 : 0);
        end
        wr_valid = 1'b0;
        status   = 1'b0;
        tick();
        chk("wr_after_done", done, 0);
        chk("wr_after_cmd_ready", cmd_ready, 1);
        $display("write addr=%0d len=%0d gap_at=%0d gap=%0d status_mid=%0d", a, len, gap_at, gap_n, raise_st);
    endtask

    task automatic do_read(input int a, input int len);
        int last;
        last = 0;
        chk("rd_idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0;
        cmd_addr = a[AW-1:0]; cmd_len = len[AW-1:0];
        tick();
        cmd_valid = 1'b0;
        chk("rd_entry_rd_valid", rd_valid, 0);
        chk("rd_entry_cmd_ready", cmd_ready, 0);
        for (int i = 0; i <= len; i++) begin
            tick();
            last = ref_mem[(a + i) % DEPTH];
            chk("rd_beat_valid", rd_valid, 1);
            chk("rd_beat_data", rd_data, last);
            chk("rd_beat_done", done, (i == len) ? 1 : 0);
        end
        tick();
        chk("rd_after_valid", rd_valid, 0);
        chk("rd_after_done", done, 0);
        chk("rd_hold_data", rd_data, last);
        chk("rd_after_cmd_ready", cmd_ready, 1);
        $display("read  addr=%0d len=%0d", a, len);
    endtask

    task automatic do_locked(input int a);
        chk("lk_idle_cmd_ready", cmd_ready, 1);
        status = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = a[AW-1:0]; cmd_len = '0;
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'hFF;
        chk("lk_err", err, 1);
        chk("lk_done", done, 0);
        chk("lk_cmd_ready", cmd_ready, 0);
        chk("lk_wr_ready", wr_ready, 0);
        tick();
        wr_valid = 1'b0;
        status   = 1'b0;
        chk("lk_err_clear", err, 0);
        chk("lk_done_after", done, 0);
        chk("lk_cmd_ready_after", cmd_ready, 1);
        $display("locked write addr=%0d rejected", a);
    endtask

    initial begin
        reset = 1'b1; status = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_len = '0; wr_data = '0; wr_valid = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);
        $display("reset released");

        // Full array: data = index, read back from 0
        for (int i = 0; i < DEPTH; i++) wbuf[i] = i;
        do_write(0, DEPTH - 1, -1, 0, 1'b0);
        do_read(0, DEPTH - 1);

        // Single word
        wbuf[0] = 8'hA5;
        do_write(3, 0, -1, 0, 1'b0);
        do_read(3, 0);

        // Wrapping burst
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        do_write(14, 3, -1, 0, 1'b0);
        do_read(14, 3);

        // Stall between beats; third word must be untouched
        wbuf[0] = $urandom_range(0, 255); wbuf[1] = $urandom_range(0, 255);
        do_write(8, 1, 1, 3, 1'b0);
        do_read(8, 2);

        // Locked write, then status raised mid-burst
        do_locked(5);
        do_read(5, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom_range(0, 255);
        do_write(10, 3, -1, 0, 1'b1);
        do_read(10, 3);

        // Reset after 2 of 4 beats
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom_range(0, 255);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd6; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = wbuf[i][DW-1:0];
            tick();
            ref_mem[6 + i] = wbuf[i];
        end
        reset   = 1'b1;
        wr_data = wbuf[2][DW-1:0];
        tick();
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_wr_ready", wr_ready, 0);
        reset    = 1'b0;
        wr_valid = 1'b0;
        tick();
        chk("abort_idle_done", done, 0);
        chk("abort_idle_cmd_ready", cmd_ready, 1);
        $display("reset mid-burst addr=6 after 2 beats");
        do_read(6, 3);

        // Randomized mix
        for (int k = 0; k < 10; k++) begin
            int op, a, len, gap_at, gap_n;
            op     = $urandom_range(0, 2);
            a      = $urandom_range(0, DEPTH - 1);
            len    = $urandom_range(0, 5);
            gap_at = $urandom_range(0, len);
            gap_n  = $urandom_range(0, 2);
            case (op)
                0: begin
                    for (int i = 0; i <= len; i++) wbuf[i] = $urandom_range(0, 255);
                    do_write(a, len, gap_at, gap_n, 1'($urandom_range(0, 1)));
                end
                1: do_read(a, len);
                default: do_locked(a);
            endcase
        end
        do_read($urandom_range(0, DEPTH - 1), DEPTH - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
